// File: rtl/icache.sv
// Direct-mapped instruction cache: combinational hit path, single outstanding line fill
// to instruction memory over the tagged-response bus.
//
// state | meaning
// IDLE  | no request pending; a miss on the fetch address starts one
// REQ   | LOAD offered to memory, waiting for the port and a nonzero response tag
// WAIT  | request accepted, waiting for the returning tag to match mem_tag
module icache #(
  parameter int NUM_LINES = 32,
  parameter int XLEN      = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] proc2Icache_addr,
  output logic [63:0]     Icache2proc_data,
  output logic            Icache2proc_data_valid,
  input  logic            mem_busy,
  output logic [1:0]      proc2Imem_command,
  output logic [XLEN-1:0] proc2Imem_addr,
  input  logic [3:0]      Imem2proc_response,
  input  logic [63:0]     Imem2proc_data,
  input  logic [3:0]      Imem2proc_tag
);

  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = XLEN - IDX_BITS - 3;

  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [XLEN-1:0]       miss_addr_q, miss_addr_d;
  logic [3:0]            mem_tag_q, mem_tag_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [63:0]           data_q [NUM_LINES];
  logic [TAG_BITS-1:0]   tags_q [NUM_LINES];

  logic [IDX_BITS-1:0]   req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [IDX_BITS-1:0]   fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [XLEN-1:0]       line_addr;
  logic                  hit;
  logic                  fill;
  logic                  unused_addr_bits;

  assign req_idx   = proc2Icache_addr[IDX_BITS+2:3];
  assign req_tag   = proc2Icache_addr[XLEN-1:IDX_BITS+3];
  assign line_addr = {proc2Icache_addr[XLEN-1:3], 3'b000};
  assign fill_idx  = miss_addr_q[IDX_BITS+2:3];
  assign fill_tag  = miss_addr_q[XLEN-1:IDX_BITS+3];

  assign unused_addr_bits = ^proc2Icache_addr[2:0];

  // Hit path reads the arrays only, so it keeps serving while a fill is outstanding.
  assign hit                    = valid_q[req_idx] && (tags_q[req_idx] == req_tag);
  assign Icache2proc_data_valid = hit;
  assign Icache2proc_data       = data_q[req_idx];
  assign proc2Imem_addr         = miss_addr_q;

  always_comb begin
    state_d           = state_q;
    miss_addr_d       = miss_addr_q;
    mem_tag_d         = mem_tag_q;
    fill              = 1'b0;
    proc2Imem_command = BUS_NONE;

    unique case (state_q)
      S_IDLE: begin
        if (!hit) begin
          miss_addr_d = line_addr;
          state_d     = S_REQ;
        end
      end

      S_REQ: begin
        if (!mem_busy) begin
          proc2Imem_command = BUS_LOAD;
        end
        if (!mem_busy && (Imem2proc_response != 4'd0)) begin
          mem_tag_d = Imem2proc_response;
          state_d   = S_WAIT;
        end else if (hit) begin
          state_d = S_IDLE;
        end else begin
          // Nothing is in flight yet, so follow the fetch stage to its new line.
          miss_addr_d = line_addr;
        end
      end

      S_WAIT: begin
        if ((Imem2proc_tag == mem_tag_q) && (Imem2proc_tag != 4'd0)) begin
          fill    = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (fill) begin
      valid_d[fill_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      mem_tag_q   <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      mem_tag_q   <= mem_tag_d;
      valid_q     <= valid_d;
    end
  end

  // Line storage is left unreset; the valid bits qualify every entry.
  always_ff @(posedge clock) begin
    if (fill) begin
      data_q[fill_idx] <= Imem2proc_data;
      tags_q[fill_idx] <= fill_tag;
    end
  end

endmodule
